// File: rtl/alu_req_master.sv
// -----------------------------------------------------------------------------
// alu_req_master
//   Issues one operation at a time to the ALU core and returns its result.
//   A request accepted on the valid/ready channel is latched, presented to the
//   ALU with CE and INP_VALID asserted for (latency + 1) cycles, and the ALU
//   result and flags are captured at the end of that window. The captured
//   values are then offered on the response valid/ready channel.
//
// Ports
//   clk_i, rst_ni            clock (rising edge), asynchronous active-low reset
//   req_valid_i/req_ready_o  request handshake (ready only while idle)
//   req_opa_i/req_opb_i      request operands
//   req_cmd_i/req_mode_i     request command and mode
//   req_cin_i                request carry-in
//   opa_o/opb_o/cmd_o/
//   mode_o/cin_o             latched payload driven to the ALU
//   ce_o, inp_valid_o        ALU clock enable and operand-valid qualifiers
//   res_i, cout_i, oflow_i,
//   err_i, e_i, g_i, l_i     ALU result and flags
//   rsp_valid_o/rsp_ready_i  response handshake
//   rsp_res_o, rsp_flags_o   captured result and {err,oflow,cout,g,l,e}
//   busy_o                   high whenever an operation is in progress
//   err_cnt_o                saturating count of responses with err set
// -----------------------------------------------------------------------------
module alu_req_master #(
  parameter int DW        = 8,
  parameter int CW        = 4,
  parameter int LAT       = 1,
  parameter int LAT_MUL   = 2,
  parameter int MUL_CMD_A = 9,
  parameter int MUL_CMD_B = 10
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [DW-1:0]   req_opa_i,
  input  logic [DW-1:0]   req_opb_i,
  input  logic [CW-1:0]   req_cmd_i,
  input  logic            req_mode_i,
  input  logic            req_cin_i,
  output logic [DW-1:0]   opa_o,
  output logic [DW-1:0]   opb_o,
  output logic [CW-1:0]   cmd_o,
  output logic            mode_o,
  output logic            cin_o,
  output logic            ce_o,
  output logic [1:0]      inp_valid_o,
  input  logic [2*DW-1:0] res_i,
  input  logic            cout_i,
  input  logic            oflow_i,
  input  logic            err_i,
  input  logic            e_i,
  input  logic            g_i,
  input  logic            l_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [2*DW-1:0] rsp_res_o,
  output logic [5:0]      rsp_flags_o,
  output logic            busy_o,
  output logic [7:0]      err_cnt_o
);

  localparam int LAT_MAX = (LAT > LAT_MUL) ? LAT : LAT_MUL;
  localparam int CNTW    = $clog2(LAT_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t          state_q;
  logic [DW-1:0]   opa_q, opb_q;
  logic [CW-1:0]   cmd_q;
  logic            mode_q, cin_q;
  logic            ce_q;
  logic [1:0]      inp_valid_q;
  logic [CNTW-1:0] lat_q, cnt_q;
  logic            rsp_valid_q;
  logic [2*DW-1:0] rsp_res_q;
  logic [5:0]      rsp_flags_q;
  logic [7:0]      err_cnt_q;

  logic            is_mul_d;
  logic [CNTW-1:0] lat_d;
  logic [7:0]      err_cnt_d;

  // Latency is chosen from the request itself so it is fixed at acceptance.
  always_comb begin
    is_mul_d  = req_mode_i && ((req_cmd_i == CW'(MUL_CMD_A)) ||
                               (req_cmd_i == CW'(MUL_CMD_B)));
    lat_d     = is_mul_d ? CNTW'(LAT_MUL) : CNTW'(LAT);
    err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      opa_q       <= '0;
      opb_q       <= '0;
      cmd_q       <= '0;
      mode_q      <= 1'b0;
      cin_q       <= 1'b0;
      ce_q        <= 1'b0;
      inp_valid_q <= 2'b00;
      lat_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_res_q   <= '0;
      rsp_flags_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            opa_q       <= req_opa_i;
            opb_q       <= req_opb_i;
            cmd_q       <= req_cmd_i;
            mode_q      <= req_mode_i;
            cin_q       <= req_cin_i;
            lat_q       <= lat_d;
            // CE rises together with ISSUE so it spans ISSUE plus all of WAIT.
            ce_q        <= 1'b1;
            inp_valid_q <= 2'b11;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt_q   <= lat_q;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt_q == CNTW'(1)) begin
            rsp_res_q   <= res_i;
            rsp_flags_q <= {err_i, oflow_i, cout_i, g_i, l_i, e_i};
            rsp_valid_q <= 1'b1;
            if (err_i) begin
              err_cnt_q <= err_cnt_d;
            end
            ce_q        <= 1'b0;
            inp_valid_q <= 2'b00;
            state_q     <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - CNTW'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o = (state_q == ST_IDLE);
  assign busy_o      = (state_q != ST_IDLE);
  assign opa_o       = opa_q;
  assign opb_o       = opb_q;
  assign cmd_o       = cmd_q;
  assign mode_o      = mode_q;
  assign cin_o       = cin_q;
  assign ce_o        = ce_q;
  assign inp_valid_o = inp_valid_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_res_o   = rsp_res_q;
  assign rsp_flags_o = rsp_flags_q;
  assign err_cnt_o   = err_cnt_q;

endmodule
